// File: rtl/exu_wb_arb.sv
// Write-back arbiter: three execution units (ALU, MDU, LSU) share one register-file
// write port under round-robin priority, with a one-cycle registered write path.
module exu_wb_arb #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          alu_valid_i,
    input  logic          mdu_valid_i,
    input  logic          lsu_valid_i,
    input  logic [DW-1:0] alu_wdata_i,
    input  logic [DW-1:0] mdu_wdata_i,
    input  logic [DW-1:0] lsu_wdata_i,
    input  logic [AW-1:0] alu_waddr_i,
    input  logic [AW-1:0] mdu_waddr_i,
    input  logic [AW-1:0] lsu_waddr_i,
    output logic          alu_ready_o,
    output logic          mdu_ready_o,
    output logic          lsu_ready_o,
    output logic          reg_we_o,
    output logic [AW-1:0] reg_waddr_o,
    output logic [DW-1:0] reg_wdata_o,
    output logic [1:0]    grant_id_o
);

    // Handshake: a result moves when valid and ready are both high in the same
    // cycle; a source keeps valid, wdata and waddr stable until it sees ready.

    localparam logic [1:0] GID_NONE = 2'd3;

    logic [1:0]    ptr_q, ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [1:0]    gid_q, gid_d;

    logic [1:0]    ptr_eff;
    logic [2:0]    valid_vec;
    logic [2:0]    ready_vec;
    logic          gnt_found;
    logic [1:0]    gnt_idx;
    logic [2:0]    sum;
    logic [1:0]    cand;
    logic [AW-1:0] sel_waddr;
    logic [DW-1:0] sel_wdata;

    // Round-robin search; walking the order backwards lets the earliest valid win.
    always_comb begin
        ptr_eff   = (ptr_q == 2'd3) ? 2'd0 : ptr_q;
        valid_vec = {lsu_valid_i, mdu_valid_i, alu_valid_i};
        gnt_found = 1'b0;
        gnt_idx   = 2'd0;
        sum       = 3'd0;
        cand      = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            sum = {1'b0, ptr_eff} + 3'(k);
            if (sum >= 3'd3) sum = sum - 3'd3;
            cand = sum[1:0];
            if (valid_vec[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        ready_vec = 3'b000;
        if (!rst) begin
            if (flush_i)        ready_vec = valid_vec;
            else if (gnt_found) ready_vec[gnt_idx] = 1'b1;
        end
    end

    assign alu_ready_o = ready_vec[0];
    assign mdu_ready_o = ready_vec[1];
    assign lsu_ready_o = ready_vec[2];

    always_comb begin
        sel_waddr = alu_waddr_i;
        sel_wdata = alu_wdata_i;
        case (gnt_idx)
            2'd1: begin
                sel_waddr = mdu_waddr_i;
                sel_wdata = mdu_wdata_i;
            end
            2'd2: begin
                sel_waddr = lsu_waddr_i;
                sel_wdata = lsu_wdata_i;
            end
            default: ;
        endcase
    end

    // Flush drains accepted results without writing and leaves priority alone.
    always_comb begin
        ptr_d   = ptr_eff;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        gid_d   = GID_NONE;
        if (!flush_i && gnt_found) begin
            ptr_d   = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
            we_d    = (sel_waddr != '0);
            waddr_d = sel_waddr;
            wdata_d = sel_wdata;
            gid_d   = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= 2'd0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            gid_q   <= GID_NONE;
        end else begin
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            gid_q   <= gid_d;
        end
    end

    assign reg_we_o    = we_q;
    assign reg_waddr_o = waddr_q;
    assign reg_wdata_o = wdata_q;
    assign grant_id_o  = gid_q;

endmodule

// File: tb/tb_exu_wb_arb.sv
// Directed bench for exu_wb_arb: inputs change 1ns after a rising edge, ready is
// sampled in mid-cycle, registered outputs are sampled 1ns after the next edge.
module tb_exu_wb_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        alu_valid_i, mdu_valid_i, lsu_valid_i;
    logic [31:0] alu_wdata_i, mdu_wdata_i, lsu_wdata_i;
    logic [4:0]  alu_waddr_i, mdu_waddr_i, lsu_waddr_i;
    logic        alu_ready_o, mdu_ready_o, lsu_ready_o;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic [1:0]  grant_id_o;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    exu_wb_arb #(.DW(32), .AW(5)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .alu_valid_i(alu_valid_i), .mdu_valid_i(mdu_valid_i), .lsu_valid_i(lsu_valid_i),
        .alu_wdata_i(alu_wdata_i), .mdu_wdata_i(mdu_wdata_i), .lsu_wdata_i(lsu_wdata_i),
        .alu_waddr_i(alu_waddr_i), .mdu_waddr_i(mdu_waddr_i), .lsu_waddr_i(lsu_waddr_i),
        .alu_ready_o(alu_ready_o), .mdu_ready_o(mdu_ready_o), .lsu_ready_o(lsu_ready_o),
        .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
        .grant_id_o(grant_id_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic mv, input logic lv);
        alu_valid_i = av;
        mdu_valid_i = mv;
        lsu_valid_i = lv;
    endtask

    task automatic chk_ready(input string tag, input logic [2:0] exp);
        #3;
        chk(tag, {29'd0, lsu_ready_o, mdu_ready_o, alu_ready_o}, {29'd0, exp});
    endtask

    task automatic chk_out(input string tag, input logic we, input logic [1:0] gid);
        chk({tag, "_we"}, {31'd0, reg_we_o}, {31'd0, we});
        chk({tag, "_gid"}, {30'd0, grant_id_o}, {30'd0, gid});
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b1;
        drive(1, 1, 1);
        alu_wdata_i = 32'h0; mdu_wdata_i = 32'h0; lsu_wdata_i = 32'h0;
        alu_waddr_i = 5'd0;  mdu_waddr_i = 5'd0;  lsu_waddr_i = 5'd0;
        #1;
        chk_ready("rst_ready_flush", 3'b000);
        tick();
        tick();
        chk_out("rst", 1'b0, 2'd3);
        chk("rst_waddr", {27'd0, reg_waddr_o}, 32'd0);
        chk("rst_wdata", reg_wdata_o, 32'd0);
        chk("rst_ptr", {30'd0, dut.ptr_q}, 32'd0);

        // Single ALU transfer.
        rst = 1'b0;
        flush_i = 1'b0;
        drive(1, 0, 0);
        alu_waddr_i = 5'd5; alu_wdata_i = 32'h1234;
        chk_ready("alu_single_ready", 3'b001);
        tick();
        drive(0, 0, 0);
        chk_out("alu_single", 1'b1, 2'd0);
        chk("alu_single_waddr", {27'd0, reg_waddr_o}, 32'd5);
        chk("alu_single_wdata", reg_wdata_o, 32'h1234);
        chk("alu_single_ptr", {30'd0, dut.ptr_q}, 32'd1);

        // Idle cycles hold the last address/data.
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("idle", 1'b0, 2'd3);
            chk("idle_waddr", {27'd0, reg_waddr_o}, 32'd5);
            chk("idle_wdata", reg_wdata_o, 32'h1234);
        end
        chk("idle_ptr", {30'd0, dut.ptr_q}, 32'd1);

        // LSU write to x0: accepted, no write enable, pointer wraps to 0.
        drive(0, 0, 1);
        lsu_waddr_i = 5'd0; lsu_wdata_i = 32'hFFFF_FFFF;
        chk_ready("x0_ready", 3'b100);
        tick();
        drive(0, 0, 0);
        chk_out("x0", 1'b0, 2'd2);
        chk("x0_ptr", {30'd0, dut.ptr_q}, 32'd0);

        // All three valid: ALU, MDU, LSU, ALU.
        alu_waddr_i = 5'd1; alu_wdata_i = 32'hA1;
        mdu_waddr_i = 5'd2; mdu_wdata_i = 32'hB2;
        lsu_waddr_i = 5'd3; lsu_wdata_i = 32'hC3;
        drive(1, 1, 1);
        chk_ready("rr0_ready", 3'b001);
        tick();
        chk_out("rr0", 1'b1, 2'd0);
        chk("rr0_waddr", {27'd0, reg_waddr_o}, 32'd1);
        chk("rr1_ready_pre", {29'd0, lsu_ready_o, mdu_ready_o, alu_ready_o}, 32'b010);
        tick();
        chk_out("rr1", 1'b1, 2'd1);
        chk("rr1_wdata", reg_wdata_o, 32'hB2);
        chk("rr2_ready_pre", {29'd0, lsu_ready_o, mdu_ready_o, alu_ready_o}, 32'b100);
        tick();
        chk_out("rr2", 1'b1, 2'd2);
        chk("rr2_wdata", reg_wdata_o, 32'hC3);
        chk("rr3_ready_pre", {29'd0, lsu_ready_o, mdu_ready_o, alu_ready_o}, 32'b001);
        tick();
        chk_out("rr3", 1'b1, 2'd0);
        chk("rr3_waddr", {27'd0, reg_waddr_o}, 32'd1);
        chk("rr3_ptr", {30'd0, dut.ptr_q}, 32'd1);

        // Flush in the cycle the ALU write is presented: write stays visible,
        // both pending results are drained.
        flush_i = 1'b1;
        drive(1, 1, 0);
        chk_out("flush_keep", 1'b1, 2'd0);
        chk_ready("flush_ready", 3'b011);
        tick();
        chk_out("flush_next", 1'b0, 2'd3);
        chk("flush_ptr", {30'd0, dut.ptr_q}, 32'd1);

        drive(1, 1, 1);
        chk_ready("flush_all_ready", 3'b111);
        tick();
        chk_out("flush_all_next", 1'b0, 2'd3);
        chk("flush_all_ptr", {30'd0, dut.ptr_q}, 32'd1);

        // MDU accepted, then reset asserted the following cycle.
        flush_i = 1'b0;
        drive(0, 1, 0);
        mdu_waddr_i = 5'd7; mdu_wdata_i = 32'h77;
        chk_ready("mdu_ready", 3'b010);
        tick();
        chk_out("mdu", 1'b1, 2'd1);
        chk("mdu_waddr", {27'd0, reg_waddr_o}, 32'd7);
        rst = 1'b1;
        drive(1, 1, 0);
        chk_ready("midrst_ready", 3'b000);
        tick();
        chk_out("midrst", 1'b0, 2'd3);
        chk("midrst_ptr", {30'd0, dut.ptr_q}, 32'd0);
        chk("midrst_waddr", {27'd0, reg_waddr_o}, 32'd0);

        // Wrap-around search from ptr=2: order LSU, ALU, MDU.
        rst = 1'b0;
        drive(0, 1, 1);
        chk_ready("p0_mdu_ready", 3'b010);
        tick();
        chk_out("p0_mdu", 1'b1, 2'd1);
        chk("p2_ptr", {30'd0, dut.ptr_q}, 32'd2);
        drive(1, 1, 0);
        chk_ready("p2_alu_ready", 3'b001);
        tick();
        drive(0, 0, 0);
        chk_out("p2_alu", 1'b1, 2'd0);
        chk("p2_alu_wdata", reg_wdata_o, 32'hA1);
        chk("p2_next_ptr", {30'd0, dut.ptr_q}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
